alu_unit: RTL and testbench
===========================

Name: alu_unit

Overview:
- RV32I-class integer ALU for the single-cycle datapath, between the register file / immediate mux and the writeback / PC-branch logic.
- Computes one of eight operations on two WIDTH-bit operands, selected by a 3-bit ALUControl code from the ALU decoder.
- Provides a combinational result and zero flag (used same-cycle for address generation and BEQ), plus a registered copy of both for debug/trace.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, ≥ 8).
- SHAMT_W, $clog2(WIDTH) = 5, shift-amount width taken from b[SHAMT_W-1:0].

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  operand A (rs1 value).
- b  input  WIDTH  operand B (rs2 value or sign-extended immediate).
- ALUControl  input  3  operation select.
- result  output  WIDTH  combinational ALU result.
- zero  output  1  combinational; 1 when result == 0.
- negative  output  1  combinational; result[WIDTH-1].
- overflow  output  1  combinational; signed overflow of add/sub, 0 for other ops.
- carry  output  1  combinational; carry-out of the adder for add/sub, 0 for other ops.
- result_q  output  WIDTH  result registered on clk.
- zero_q  output  1  zero registered on clk.

Behaviour:
- ALUControl encoding:
  - 000 ADD: a + b, modulo 2^WIDTH.
  - 001 SUB: a - b, computed as a + ~b + 1.
  - 010 AND: a & b.
  - 011 OR: a | b.
  - 100 XOR: a ^ b.
  - 101 SLT (signed): result = {WIDTH-1 zeros, lt}, with lt = sub_msb XOR sub_overflow.
  - 110 SLL: a << b[SHAMT_W-1:0].
  - 111 SRL (logical): a >> b[SHAMT_W-1:0].
- result, zero, negative, overflow, carry are purely combinational, zero latency: valid within the same cycle as the inputs, with no dependence on clk or reset.
- Single shared adder/subtractor serves ADD, SUB and SLT. Carry = adder carry-out; for SUB, carry = 1 means no borrow (a ≥ b unsigned).
- Overflow:
  - ADD: (a[msb] == b[msb]) && (sum[msb] != a[msb]).
  - SUB/SLT: (a[msb] != b[msb]) && (diff[msb] != a[msb]).
  - SLT drives the overflow output 0; overflow is used internally only.
- Shift amount uses only the low SHAMT_W bits of b; upper bits are ignored (b = 33 shifts by 1).
- Every code 000–111 is defined; there is no X output for any select value.
- Registered path:
  - On rising clk with reset = 1: result_q ← 0, zero_q ← 1 (consistent with result_q == 0).
  - Otherwise: result_q ← result, zero_q ← zero.
  - One-cycle latency.
  - Reset has no effect on the combinational outputs.

Decomposition:
- Shared package alu_pkg:
  - ALUControl codes as localparams/enum: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL.
  - Default WIDTH.
- Imported by alu_unit and the ALU decoder.
- One natural sub-module: alu_addsub (WIDTH-bit add/subtract with carry and overflow outputs).
- Logic ops, shifter and output register remain inline.

Test Plan:
- ADD/address: a=10, b=5, ctl=000 -> result=15. a=1000, b=20, ctl=000 -> result=1020, zero=0. a=0xFFFFFFFF, b=1 -> result=0, zero=1, carry=1, overflow=0.
- SUB/BEQ: a=10, b=3, ctl=001 -> result=7. a=42, b=42 -> zero=1. a=42, b=43 -> zero=0, result=0xFFFFFFFF, negative=1. a=0x80000000, b=1 -> overflow=1.
- Logic:
  - a=0xFF00FF00, b=0x0F0F0F0F: ctl=010 -> 0x0F000F00.
  - a=0xF0000000, b=0x0F000000: ctl=011 -> 0xFF000000.
  - a=0x0000000F, b=0x000000F0: ctl=011 -> 0x000000FF; ctl=100 -> 0x000000FF.
- SLT: (3,4) -> 1. (10,2) -> 0. (7,8) -> 1. (9,3) -> 0. (0xFFFFFFFF, 1) -> 1 (signed -1 < 1). (0x7FFFFFFF, 0x80000000) -> 0.
- Shifts: a=1, b=31, ctl=110 -> 0x80000000. a=0x80000000, b=33, ctl=111 -> 0x40000000.
- Register path: hold reset=1 for one edge -> result_q=0, zero_q=1. Release reset; drive a=10, b=5, ctl=000 -> result=15 same cycle, result_q=15 after the next rising edge. Assert reset with nonzero inputs -> result_q=0 after the edge while result stays 15.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation select codes and the default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_unit_if.sv
// Operand/select bundle into the ALU and the flag/result bundle coming back out.
interface alu_unit_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             overflow;
  logic             carry;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  modport master (
    output a, b, ALUControl,
    input  result, zero, negative, overflow, carry, result_q, zero_q
  );

  modport slave (
    input  a, b, ALUControl,
    output result, zero, negative, overflow, carry, result_q, zero_q
  );

endinterface

// File: rtl/alu_addsub.sv
// Shared WIDTH-bit adder/subtractor; subtraction is a + ~b + 1 so carry=1 means no borrow.
module alu_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;

  // Invert B and inject the +1 through the carry-in when subtracting; overflow
  // compares the effective operand signs against the sum sign.
  always_comb begin
    b_eff           = sub ? ~b : b;
    {carry, sum}    = {1'b0, a} + {1'b0, b_eff} + (WIDTH + 1)'(sub);
    overflow        = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_unit.sv
// RV32I-class ALU: combinational result and flags, plus a registered result/zero copy for trace.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset,
  alu_unit_if.slave  bus
);

  logic [WIDTH-1:0]   sum;
  logic               add_carry;
  logic               add_overflow;
  logic               do_sub;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   result_c;
  logic               overflow_c;
  logic               carry_c;
  logic               zero_c;

  assign do_sub = (bus.ALUControl == ALU_SUB) || (bus.ALUControl == ALU_SLT);
  assign shamt  = bus.b[SHAMT_W-1:0];

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a        (bus.a),
    .b        (bus.b),
    .sub      (do_sub),
    .sum      (sum),
    .carry    (add_carry),
    .overflow (add_overflow)
  );

  // Operation select; flags only come from the adder for ADD/SUB, SLT keeps its overflow internal.
  always_comb begin
    result_c   = '0;
    overflow_c = 1'b0;
    carry_c    = 1'b0;
    case (bus.ALUControl)
      ALU_ADD: begin
        result_c   = sum;
        overflow_c = add_overflow;
        carry_c    = add_carry;
      end
      ALU_SUB: begin
        result_c   = sum;
        overflow_c = add_overflow;
        carry_c    = add_carry;
      end
      ALU_AND: result_c = bus.a & bus.b;
      ALU_OR:  result_c = bus.a | bus.b;
      ALU_XOR: result_c = bus.a ^ bus.b;
      ALU_SLT: result_c = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ add_overflow};
      ALU_SLL: result_c = bus.a << shamt;
      ALU_SRL: result_c = bus.a >> shamt;
      default: result_c = '0;
    endcase
  end

  assign zero_c       = (result_c == '0);
  assign bus.result   = result_c;
  assign bus.zero     = zero_c;
  assign bus.negative = result_c[WIDTH-1];
  assign bus.overflow = overflow_c;
  assign bus.carry    = carry_c;

  // Trace register; reset value keeps zero_q consistent with result_q == 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.result_q <= '0;
      bus.zero_q   <= 1'b1;
    end else begin
      bus.result_q <= result_c;
      bus.zero_q   <= zero_c;
    end
  end

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: stimulus pushes transactions, a negedge monitor checks them
// against an arithmetic reference model and tracks the expected registered copy.
module tb_alu_unit;
  import alu_pkg::*;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic        rst;
  } txn_t;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        negative;
    logic        overflow;
    logic        carry;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  txn_t sb_q[$];
  logic have_prev;
  logic [31:0] exp_rq;
  logic        exp_zq;

  alu_unit_if #(.WIDTH(32)) bus ();

  alu_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: exact signed/unsigned arithmetic, no bit-level adder.
  function automatic exp_t refModel(logic [31:0] a, logic [31:0] b, logic [2:0] op);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      sr;
    logic [32:0] wide;
    logic [4:0]  sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    e.overflow = 1'b0;
    e.carry    = 1'b0;
    e.result   = '0;
    case (op)
      3'b000: begin
        wide       = {1'b0, a} + {1'b0, b};
        e.result   = wide[31:0];
        e.carry    = wide[32];
        sr         = sa + sb;
        e.overflow = (sr != longint'($signed(e.result)));
      end
      3'b001: begin
        e.result   = a - b;
        e.carry    = (a >= b);
        sr         = sa - sb;
        e.overflow = (sr != longint'($signed(e.result)));
      end
      3'b010: e.result = a & b;
      3'b011: e.result = a | b;
      3'b100: e.result = a ^ b;
      3'b101: e.result = (sa < sb) ? 32'd1 : 32'd0;
      3'b110: e.result = a << sh;
      default: e.result = a >> sh;
    endcase
    e.zero     = (e.result == 32'd0);
    e.negative = e.result[31];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op, input logic rst);
    txn_t t;
    @(posedge clk);
    #1;
    bus.a          = a;
    bus.b          = b;
    bus.ALUControl = op;
    reset          = rst;
    t.a = a; t.b = b; t.op = op; t.rst = rst;
    sb_q.push_back(t);
  endtask

  // Monitor: combinational outputs against the current transaction, registered
  // outputs against what the previous transaction should have captured.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      txn_t t;
      exp_t e;
      t = sb_q.pop_front();
      e = refModel(t.a, t.b, t.op);
      checkOutput($sformatf("result op=%0d a=%h b=%h", t.op, t.a, t.b), bus.result, e.result);
      checkOutput("zero", {31'd0, bus.zero}, {31'd0, e.zero});
      checkOutput("negative", {31'd0, bus.negative}, {31'd0, e.negative});
      checkOutput("overflow", {31'd0, bus.overflow}, {31'd0, e.overflow});
      checkOutput("carry", {31'd0, bus.carry}, {31'd0, e.carry});
      if (have_prev) begin
        checkOutput("result_q", bus.result_q, exp_rq);
        checkOutput("zero_q", {31'd0, bus.zero_q}, {31'd0, exp_zq});
      end
      exp_rq    = t.rst ? 32'd0 : e.result;
      exp_zq    = t.rst ? 1'b1 : e.zero;
      have_prev = 1'b1;
    end
  end

  initial begin
    total          = 0;
    bad            = 0;
    have_prev      = 1'b0;
    exp_rq         = '0;
    exp_zq         = 1'b1;
    reset          = 1'b1;
    bus.a          = '0;
    bus.b          = '0;
    bus.ALUControl = 3'b000;

    // Reset for one edge, then the register path scenario.
    applyStimulus(32'd0, 32'd0, ALU_ADD, 1'b1);
    applyStimulus(32'd10, 32'd5, ALU_ADD, 1'b0);
    applyStimulus(32'd10, 32'd5, ALU_ADD, 1'b1);
    applyStimulus(32'd10, 32'd5, ALU_ADD, 1'b0);

    // Directed vectors.
    applyStimulus(32'd1000, 32'd20, ALU_ADD, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'd1, ALU_ADD, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'd1, ALU_ADD, 1'b0);
    applyStimulus(32'd10, 32'd3, ALU_SUB, 1'b0);
    applyStimulus(32'd42, 32'd42, ALU_SUB, 1'b0);
    applyStimulus(32'd42, 32'd43, ALU_SUB, 1'b0);
    applyStimulus(32'h80000000, 32'd1, ALU_SUB, 1'b0);
    applyStimulus(32'hFF00FF00, 32'h0F0F0F0F, ALU_AND, 1'b0);
    applyStimulus(32'hF0000000, 32'h0F000000, ALU_OR, 1'b0);
    applyStimulus(32'h0000000F, 32'h000000F0, ALU_OR, 1'b0);
    applyStimulus(32'h0000000F, 32'h000000F0, ALU_XOR, 1'b0);
    applyStimulus(32'd3, 32'd4, ALU_SLT, 1'b0);
    applyStimulus(32'd10, 32'd2, ALU_SLT, 1'b0);
    applyStimulus(32'd7, 32'd8, ALU_SLT, 1'b0);
    applyStimulus(32'd9, 32'd3, ALU_SLT, 1'b0);
    applyStimulus(32'hFFFFFFFF, 32'd1, ALU_SLT, 1'b0);
    applyStimulus(32'h7FFFFFFF, 32'h80000000, ALU_SLT, 1'b0);
    applyStimulus(32'h80000000, 32'h7FFFFFFF, ALU_SLT, 1'b0);
    applyStimulus(32'd1, 32'd31, ALU_SLL, 1'b0);
    applyStimulus(32'h80000000, 32'd33, ALU_SRL, 1'b0);
    applyStimulus(32'h12345678, 32'hFFFFFFE4, ALU_SLL, 1'b0);

    // Randomized operands, biased toward sign/carry boundaries.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 3))
        0: ra = {ra[0], 30'd0, ra[1]} ^ 32'h7FFFFFFF;
        1: rb = ra ^ {31'd0, rb[0]};
        2: rb = {27'd0, rb[4:0]};
        default: ;
      endcase
      applyStimulus(ra, rb, 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0));
    end
    applyStimulus(32'd0, 32'd0, ALU_ADD, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int w = 0; w < 20 && sb_q.size() > 0; w++) @(posedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain pending=%0d required=0", sb_q.size());
    end
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
